// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : stall/flush sequencer for the RV32 pipeline register chain
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int NSTAGES    = 4,
    parameter int MC_TIMEOUT = 64,
    parameter int PERF_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_busy_i,
    input  logic               redirect_i,
    input  logic               ld_use_i,
    input  logic               mc_start_i,
    input  logic               mc_done_i,
    input  logic               halt_req_i,
    input  logic               resume_i,
    output logic [NSTAGES-1:0] stage_en_o,
    output logic [NSTAGES-1:0] stage_clr_n_o,
    output logic               pc_en_o,
    output logic               mc_ack_o,
    output logic               halted_o,
    output logic [1:0]         state_o,
    output logic               mc_err_o,
    output logic [PERF_W-1:0]  stall_cnt_o
);

    localparam int IFID  = NSTAGES - 1;
    localparam int IDEX  = NSTAGES - 2;
    localparam int EXMEM = NSTAGES - 3;
    localparam int WD_W  = $clog2(MC_TIMEOUT + 1);
    localparam int DR_W  = $clog2(NSTAGES + 1);
    localparam logic [NSTAGES-1:0] UPPER_M = {2'b11, {(NSTAGES-2){1'b0}}};
    localparam logic [NSTAGES-1:0] LOW_M   = ~UPPER_M;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MC_WAIT = 2'd1,
        S_DRAIN   = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NSTAGES-1:0] kill_q, kill_d;
    logic               halt_pend_q, halt_pend_d;
    logic               ack_pend_q, ack_pend_d;
    logic               mc_err_q, mc_err_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [DR_W-1:0]    drain_q, drain_d;
    logic [PERF_W-1:0]  stall_q, stall_d;

    logic [NSTAGES-1:0] en_raw, en;
    logic               pc_raw, pc;
    logic               mc_ack;
    logic               redirect_v, mc_start_v, ld_use_v, wd_fire, mc_fin;

    // A stage being cleared this cycle cannot vouch for the hazard it reports.
    assign redirect_v = redirect_i & ~kill_q[IDEX];
    assign mc_start_v = mc_start_i & ~kill_q[IDEX];
    assign ld_use_v   = ld_use_i   & ~kill_q[IFID];
    assign wd_fire    = (wd_q == WD_W'(MC_TIMEOUT - 1)) & ~mc_done_i;
    assign mc_fin     = mc_done_i | wd_fire;

    always_comb begin
        logic acc;
        acc = 1'b0;
        for (int j = 0; j < NSTAGES; j++) begin
            en[j] = en_raw[j] & ~acc & rst_n;
            acc   = acc | kill_q[j];
        end
        pc     = pc_raw & ~(|kill_q) & rst_n;
        mc_ack = ack_pend_q & en[EXMEM] & ~mem_busy_i;
    end

    always_comb begin
        state_d     = state_q;
        kill_d      = '0;
        halt_pend_d = halt_pend_q;
        ack_pend_d  = ack_pend_q & ~mc_ack;
        mc_err_d    = mc_err_q;
        wd_d        = wd_q;
        drain_d     = drain_q;
        en_raw      = '0;
        pc_raw      = 1'b0;

        if (!mem_busy_i) begin
            case (state_q)
                S_RUN: begin
                    en_raw = '1;
                    pc_raw = 1'b1;
                    if (redirect_v) begin
                        kill_d = UPPER_M;
                    end else if (mc_start_v) begin
                        en_raw       = LOW_M;
                        pc_raw       = 1'b0;
                        kill_d[EXMEM] = 1'b1;
                        wd_d         = '0;
                        state_d      = S_MC_WAIT;
                    end else if (ld_use_v) begin
                        en_raw       = LOW_M;
                        pc_raw       = 1'b0;
                        kill_d[IDEX] = 1'b1;
                    end else if (halt_pend_q) begin
                        // PC holds so the discarded IF/ID instruction is refetched on resume
                        pc_raw       = 1'b0;
                        kill_d[IFID] = 1'b1;
                        halt_pend_d  = 1'b0;
                        drain_d      = '0;
                        state_d      = S_DRAIN;
                    end
                end
                S_MC_WAIT: begin
                    en_raw = LOW_M;
                    if (mc_fin) begin
                        ack_pend_d = 1'b1;
                        mc_err_d   = mc_err_q | wd_fire;
                        if (halt_pend_q) begin
                            kill_d[IFID] = 1'b1;
                            halt_pend_d  = 1'b0;
                            drain_d      = '0;
                            state_d      = S_DRAIN;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        kill_d[EXMEM] = 1'b1;
                        wd_d          = wd_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    en_raw = LOW_M;
                    if (mc_start_v && !redirect_v) begin
                        kill_d[EXMEM] = 1'b1;
                        wd_d          = '0;
                        halt_pend_d   = 1'b1;
                        state_d       = S_MC_WAIT;
                    end else begin
                        if (redirect_v) begin
                            pc_raw = 1'b1;
                            kill_d = UPPER_M;
                        end
                        if (drain_q == DR_W'(NSTAGES - 1)) begin
                            state_d = S_HALTED;
                        end else begin
                            drain_d = drain_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (resume_i) begin
                        state_d = S_RUN;
                    end
                end
            endcase
        end

        if (halt_req_i && state_q != S_HALTED) begin
            halt_pend_d = 1'b1;
        end

        stall_d = stall_q;
        if (!pc && state_q != S_HALTED && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            kill_q      <= '0;
            halt_pend_q <= 1'b0;
            ack_pend_q  <= 1'b0;
            mc_err_q    <= 1'b0;
            wd_q        <= '0;
            drain_q     <= '0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            halt_pend_q <= halt_pend_d;
            ack_pend_q  <= ack_pend_d;
            mc_err_q    <= mc_err_d;
            wd_q        <= wd_d;
            drain_q     <= drain_d;
            stall_q     <= stall_d;
        end
    end

    assign stage_en_o    = en;
    assign stage_clr_n_o = {NSTAGES{rst_n}} & ~kill_q;
    assign pc_en_o       = pc;
    assign mc_ack_o      = mc_ack;
    assign halted_o      = (state_q == S_HALTED);
    assign state_o       = state_q;
    assign mc_err_o      = mc_err_q;
    assign stall_cnt_o   = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed bench for pipe_ctrl (MC_TIMEOUT shortened to 8)
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_busy, redirect, ld_use, mc_start, mc_done, halt_req, resume;
    logic [3:0]  stage_en, stage_clr_n;
    logic        pc_en, mc_ack, halted, mc_err;
    logic [1:0]  state;
    logic [31:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    pipe_ctrl #(
        .NSTAGES    (4),
        .MC_TIMEOUT (8),
        .PERF_W     (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_busy_i    (mem_busy),
        .redirect_i    (redirect),
        .ld_use_i      (ld_use),
        .mc_start_i    (mc_start),
        .mc_done_i     (mc_done),
        .halt_req_i    (halt_req),
        .resume_i      (resume),
        .stage_en_o    (stage_en),
        .stage_clr_n_o (stage_clr_n),
        .pc_en_o       (pc_en),
        .mc_ack_o      (mc_ack),
        .halted_o      (halted),
        .state_o       (state),
        .mc_err_o      (mc_err),
        .stall_cnt_o   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        {mem_busy, redirect, ld_use, mc_start, mc_done, halt_req, resume} = '0;

        // reset state
        #3;
        chk("rst_en",    32'(stage_en),    32'h0);
        chk("rst_pc",    32'(pc_en),       32'h0);
        chk("rst_clr",   32'(stage_clr_n), 32'h0);
        chk("rst_state", 32'(state),       32'h0);
        chk("rst_ack",   32'(mc_ack),      32'h0);
        cyc(); cyc();
        rst_n = 1'b1; #2;
        chk("idle_en",    32'(stage_en),    32'hF);
        chk("idle_pc",    32'(pc_en),       32'h1);
        chk("idle_clr",   32'(stage_clr_n), 32'hF);
        chk("idle_stall", stall_cnt,        32'd0);

        // redirect
        cyc(); redirect = 1'b1; #2;
        chk("redir_n_en", 32'(stage_en), 32'hF);
        chk("redir_n_pc", 32'(pc_en),    32'h1);
        cyc(); redirect = 1'b0; #2;
        chk("redir_n1_clr", 32'(stage_clr_n), 32'h3);
        chk("redir_n1_pc",  32'(pc_en),       32'h0);
        chk("redir_n1_en",  32'(stage_en),    32'h7);
        cyc(); #2;
        chk("redir_n2_pc",  32'(pc_en),       32'h1);
        chk("redir_n2_clr", 32'(stage_clr_n), 32'hF);
        chk("redir_stall",  stall_cnt,        32'd1);

        // load-use
        cyc(); ld_use = 1'b1; #2;
        chk("lduse_n_en", 32'(stage_en), 32'h3);
        chk("lduse_n_pc", 32'(pc_en),    32'h0);
        cyc(); ld_use = 1'b0; #2;
        chk("lduse_n1_clr", 32'(stage_clr_n), 32'hB);
        chk("lduse_n1_pc",  32'(pc_en),       32'h0);
        chk("lduse_n1_en",  32'(stage_en),    32'h7);
        cyc(); #2;
        chk("lduse_n2_pc", 32'(pc_en), 32'h1);
        chk("lduse_stall", stall_cnt,   32'd3);

        // multi-cycle op completing at N+5
        cyc(); mc_start = 1'b1; #2;
        chk("mc_n_en",    32'(stage_en), 32'h3);
        chk("mc_n_pc",    32'(pc_en),    32'h0);
        chk("mc_n_state", 32'(state),    32'h0);
        cyc(); mc_start = 1'b0; #2;
        chk("mc_n1_state", 32'(state),       32'h1);
        chk("mc_n1_clr",   32'(stage_clr_n), 32'hD);
        chk("mc_n1_en",    32'(stage_en),    32'h3);
        cyc(); cyc(); cyc(); #2;
        chk("mc_n4_state", 32'(state), 32'h1);
        cyc(); mc_done = 1'b1; #2;
        chk("mc_n5_state", 32'(state),  32'h1);
        chk("mc_n5_ack",   32'(mc_ack), 32'h0);
        cyc(); #2;
        chk("mc_n6_state", 32'(state),    32'h0);
        chk("mc_n6_ack",   32'(mc_ack),   32'h1);
        chk("mc_n6_en",    32'(stage_en), 32'hF);
        chk("mc_n6_pc",    32'(pc_en),    32'h1);
        cyc(); mc_done = 1'b0; #2;
        chk("mc_n7_ack", 32'(mc_ack), 32'h0);
        chk("mc_stall",  stall_cnt,   32'd9);

        // watchdog: no mc_done, timeout of 8 wait cycles
        cyc(); mc_start = 1'b1; #2;
        cyc(); mc_start = 1'b0; #2;
        chk("wd_m1_state", 32'(state), 32'h1);
        for (int k = 0; k < 7; k++) cyc();
        #2;
        chk("wd_m8_state", 32'(state),  32'h1);
        chk("wd_m8_err",   32'(mc_err), 32'h0);
        cyc(); #2;
        chk("wd_m9_state", 32'(state),  32'h0);
        chk("wd_m9_err",   32'(mc_err), 32'h1);
        chk("wd_m9_ack",   32'(mc_ack), 32'h1);
        chk("wd_stall",    stall_cnt,   32'd18);
        cyc(); #2;
        chk("wd_m10_ack", 32'(mc_ack), 32'h0);
        chk("wd_m10_err", 32'(mc_err), 32'h1);

        // halt with a 2-cycle freeze in the middle of DRAIN
        cyc(); halt_req = 1'b1; #2;
        chk("halt_h_state", 32'(state), 32'h0);
        cyc(); halt_req = 1'b0; #2;
        cyc(); #2;
        chk("drain_state", 32'(state),       32'h2);
        chk("drain_clr",   32'(stage_clr_n), 32'h7);
        chk("drain_en",    32'(stage_en),    32'h3);
        chk("drain_pc",    32'(pc_en),       32'h0);
        cyc(); #2;
        cyc(); mem_busy = 1'b1; #2;
        chk("frz_en",    32'(stage_en), 32'h0);
        chk("frz_pc",    32'(pc_en),    32'h0);
        chk("frz_state", 32'(state),    32'h2);
        cyc(); #2;
        chk("frz2_state", 32'(state), 32'h2);
        cyc(); mem_busy = 1'b0; #2;
        cyc(); #2;
        chk("drain_last_halted", 32'(halted), 32'h0);
        cyc(); #2;
        chk("halted",        32'(halted),   32'h1);
        chk("halted_state",  32'(state),    32'h3);
        chk("halted_en",     32'(stage_en), 32'h0);
        chk("halted_pc",     32'(pc_en),    32'h0);

        // halt_req ignored while halted, then resume
        cyc(); halt_req = 1'b1; #2;
        chk("halted_hreq", 32'(halted), 32'h1);
        cyc(); halt_req = 1'b0; #2;
        cyc(); resume = 1'b1; #2;
        chk("resume_r_state", 32'(state), 32'h3);
        chk("resume_r_pc",    32'(pc_en), 32'h0);
        cyc(); resume = 1'b0; #2;
        chk("resume_state", 32'(state),    32'h0);
        chk("resume_pc",    32'(pc_en),    32'h1);
        chk("resume_en",    32'(stage_en), 32'hF);
        cyc(); #2;
        chk("resume_nohalt_pc", 32'(pc_en), 32'h1);

        // asynchronous reset in the middle of MC_WAIT
        cyc(); mc_start = 1'b1; #2;
        cyc(); mc_start = 1'b0; #2;
        chk("arst_pre_state", 32'(state), 32'h1);
        #1 rst_n = 1'b0; #1;
        chk("arst_clr",   32'(stage_clr_n), 32'h0);
        chk("arst_en",    32'(stage_en),    32'h0);
        chk("arst_pc",    32'(pc_en),       32'h0);
        chk("arst_state", 32'(state),       32'h0);
        chk("arst_err",   32'(mc_err),      32'h0);
        cyc(); rst_n = 1'b1; #2;
        chk("post_state", 32'(state),       32'h0);
        chk("post_err",   32'(mc_err),      32'h0);
        chk("post_stall", stall_cnt,        32'd0);
        chk("post_clr",   32'(stage_clr_n), 32'hF);
        chk("post_en",    32'(stage_en),    32'hF);
        chk("post_pc",    32'(pc_en),       32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
